// File: rtl/playfield_grid.sv
// playfield_grid: locked-cell playfield for the falling-block game.
//   Stores a COLS x ROWS bit grid (row 0 at top). A lock request ORs a 4x4
//   shape into the grid, then an FSM scans bottom-up and collapses every
//   full row before returning to IDLE.
// Ports:
//   Clk, Reset            clock, async active-high reset
//   lock_valid/ready      lock handshake (ready only in IDLE, not after game over)
//   lock_col/row/shape    shape origin (bit 0 of mask) and 4x4 mask, bit r*4+c
//   probe_col/row/shape   combinational collision probe -> probe_hit
//   DrawX, DrawY          pixel position -> drawCell (1-cycle registered)
//   lines_cleared         running count of cleared rows (wraps)
//   busy                  FSM not in IDLE
//   game_over             sticky, set when row 0 is occupied after a lock
//   score                 line score; built only with `define LINE_SCORE_EN,
//                         otherwise tied to 0
module playfield_grid #(
  parameter int COLS = 32,
  parameter int ROWS = 24,
  parameter int CELL = 20
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        lock_valid,
  output logic        lock_ready,
  input  logic [5:0]  lock_col,
  input  logic [5:0]  lock_row,
  input  logic [15:0] lock_shape,
  input  logic [5:0]  probe_col,
  input  logic [5:0]  probe_row,
  input  logic [15:0] probe_shape,
  output logic        probe_hit,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  output logic        drawCell,
  output logic [15:0] lines_cleared,
  output logic        busy,
  output logic        game_over,
  output logic [15:0] score
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_SCAN, S_SHIFT, S_FINISH} state_t;

  state_t state, state_nxt;

  logic [ROWS-1:0][COLS-1:0] grid;
  logic [ROWS-1:0][COLS-1:0] wr_mask;
  logic [5:0]    l_col, l_row;
  logic [15:0]   l_shape;
  logic [RW-1:0] scan_row, ptr;
  logic [2:0]    clears;
  logic          row_full, accept;

  assign row_full = &grid[scan_row];
  assign accept   = lock_valid & lock_ready;

  // state register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept) state_nxt = S_WRITE;
      S_WRITE:  state_nxt = S_SCAN;
      S_SCAN:   if (row_full) state_nxt = S_SHIFT;
                else if (scan_row == '0) state_nxt = S_FINISH;
      S_SHIFT:  if (ptr == '0) state_nxt = S_SCAN;
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // outputs
  always_comb begin
    lock_ready = (state == S_IDLE) && !game_over;
    busy       = (state != S_IDLE);
  end

  // latched shape expanded onto the grid; cells past the edges are dropped
  logic [6:0] wr, wc;
  always_comb begin
    wr_mask = '0;
    wr = '0;
    wc = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        wr = 7'(l_row) + 7'(r);
        wc = 7'(l_col) + 7'(c);
        if (l_shape[r*4+c] && wr < 7'(ROWS) && wc < 7'(COLS))
          wr_mask[wr[RW-1:0]][wc[CW-1:0]] = 1'b1;
      end
    end
  end

  // collision probe: off-grid cells always collide
  logic [6:0] pr, pc;
  always_comb begin
    probe_hit = 1'b0;
    pr = '0;
    pc = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        pr = 7'(probe_row) + 7'(r);
        pc = 7'(probe_col) + 7'(c);
        if (probe_shape[r*4+c]) begin
          if (pr >= 7'(ROWS) || pc >= 7'(COLS)) probe_hit = 1'b1;
          else if (grid[pr[RW-1:0]][pc[CW-1:0]]) probe_hit = 1'b1;
        end
      end
    end
  end

  // pixel -> cell lookup
  logic [9:0] cx, cy;
  logic       draw_occ;
  always_comb begin
    cx = DrawX / 10'(CELL);
    cy = DrawY / 10'(CELL);
    draw_occ = 1'b0;
    if (cx < 10'(COLS) && cy < 10'(ROWS)) draw_occ = grid[cy[RW-1:0]][cx[CW-1:0]];
  end

  // datapath
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      grid          <= '0;
      l_col         <= '0;
      l_row         <= '0;
      l_shape       <= '0;
      scan_row      <= '0;
      ptr           <= '0;
      clears        <= '0;
      lines_cleared <= '0;
      game_over     <= 1'b0;
      drawCell      <= 1'b0;
    end else begin
      drawCell <= draw_occ;
      case (state)
        S_IDLE: if (accept) begin
          l_col   <= lock_col;
          l_row   <= lock_row;
          l_shape <= lock_shape;
        end
        S_WRITE: begin
          grid     <= grid | wr_mask;
          scan_row <= RW'(ROWS - 1);
          clears   <= '0;
        end
        S_SCAN: begin
          if (row_full)              ptr      <= scan_row;
          else if (scan_row != '0)   scan_row <= scan_row - 1'b1;
        end
        // move one row per cycle; scan_row is kept so the row that drops
        // into it gets rescanned
        S_SHIFT: begin
          if (ptr == '0) begin
            grid[0] <= '0;
            clears  <= clears + 3'd1;
          end else begin
            grid[ptr] <= grid[ptr - 1'b1];
            ptr       <= ptr - 1'b1;
          end
        end
        S_FINISH: begin
          lines_cleared <= lines_cleared + 16'(clears);
          if (|grid[0]) game_over <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef LINE_SCORE_EN
  logic [3:0]  score_inc;
  logic [16:0] score_sum;
  always_comb begin
    case (clears)
      3'd1:    score_inc = 4'd1;
      3'd2:    score_inc = 4'd3;
      3'd3:    score_inc = 4'd5;
      3'd4:    score_inc = 4'd8;
      default: score_inc = 4'd0;
    endcase
    score_sum = {1'b0, score} + 17'(score_inc);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)                  score <= '0;
    else if (state == S_FINISH) score <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
  end
`else
  assign score = '0;
`endif

endmodule

// File: doc/playfield_grid.md
Name: playfield_grid

Overview:
- Downstream consumer of the falling-block stage.
- Holds the locked-cell playfield as a COLS x ROWS bit grid of CELL-pixel squares.
- Accepts lock requests carrying a 4x4 shape mask and a grid position. Writes the shape into the grid, then clears full rows with a multi-cycle FSM.
- Provides a combinational collision probe for the falling block and a registered per-pixel occupancy flag for the video mux.

Parameters:
- COLS, 32, grid columns (640/CELL).
- ROWS, 24, grid rows (480/CELL).
- CELL, 20, cell edge in pixels.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- lock_valid  in  1  lock request.
- lock_ready  out  1  high only in IDLE; a lock is accepted on a cycle with lock_valid & lock_ready.
- lock_col  in  6  grid column of shape bit 0.
- lock_row  in  6  grid row of shape bit 0.
- lock_shape  in  16  4x4 mask, bit index r*4+c, with bit 0 at top-left.
- probe_col  in  6  probe column.
- probe_row  in  6  probe row.
- probe_shape  in  16  probe mask, same encoding as lock_shape.
- probe_hit  out  1  combinational: some set probe cell overlaps a locked cell or lies outside the grid.
- DrawX  in  10  pixel X.
- DrawY  in  10  pixel Y.
- drawCell  out  1  registered occupancy of the cell containing (DrawX, DrawY).
- lines_cleared  out  16  running count of cleared rows.
- busy  out  1  FSM not in IDLE.
- game_over  out  1  sticky end-of-game flag.
- score  out  16  see Optional Feature.

Behaviour:
- Reset (async): all grid rows 0, FSM to IDLE.
  - Outputs: drawCell 0, lines_cleared 0, game_over 0, score 0, busy 0, lock_ready 1.
- Grid storage: ROWS registers of COLS bits; row 0 is the top row.
- probe_hit: pure function of the registered grid and the probe inputs.
  - A set mask cell at (probe_row+r, probe_col+c) hits if its column >= COLS, its row >= ROWS, or that grid bit is 1.
  - A zero mask gives 0.
- drawCell: 1-cycle latency.
  - Cell = (DrawX/CELL, DrawY/CELL), using constant integer divide.
  - Output 0 if the cell is outside the grid.
- FSM states:
  - IDLE: lock_ready=1. On accept, latch col, row and shape, then go to WRITE. lock_valid while not in IDLE is ignored; the source holds it.
  - WRITE (1 cycle): OR the latched mask into the grid. Out-of-grid cells are dropped. Set scan_row=ROWS-1 and clears=0, then go to SCAN.
  - SCAN (1 cycle per row): if row[scan_row] is all ones, go to SHIFT. Otherwise, if scan_row==0, go to FINISH; else decrement scan_row and stay.
  - SHIFT (1 cycle per row moved): a pointer p runs from scan_row down to 1 with row[p] <= row[p-1]. On the cycle it reaches 0, row[0] <= 0, clears++, then return to SCAN with scan_row unchanged so the row is rescanned.
  - FINISH (1 cycle):
    - lines_cleared += clears (wraps mod 2^16).
    - score update (see Optional Feature).
    - If row 0 is non-zero, set game_over.
    - Go to IDLE.
- game_over: once set, lock_ready stays 0 until Reset. probe_hit still functions.
- Latency: lock with no full rows = 1 (WRITE) + ROWS (SCAN) + 1 (FINISH) cycles of busy.
- Reset mid-operation: asynchronously aborts any state; a partial shift is discarded and the grid is cleared.

Optional Feature:
- Macro LINE_SCORE_EN.
- Defined: in FINISH, score += 0/1/3/5/8 for clears = 0/1/2/3/4, saturating at 16'hFFFF.
- Undefined: score is tied to 0 and no scoring logic is built; lines_cleared is unaffected.

Test Plan:
- Reset, then lock shape 16'h000F at col 0, row 23 (one horizontal 4-cell row) -> grid row 23 bits 0-3 set; drawCell=1 at DrawX=10, DrawY=470 one cycle after presentation; busy for 26 cycles; lines_cleared=0.
- Prefill row 23 cols 4-31 via locks, then lock 16'h000F at col 0, row 23 -> row 23 cleared, content above shifts down one row, lines_cleared=1, score=1 with LINE_SCORE_EN.
- Fill cols 1-31 of rows 20-23, then lock vertical 16'h1111 at col 0, row 20 -> four clears, rows 0-3 zero, lines_cleared=4, score=8 with LINE_SCORE_EN, 0 without.
- Probe 16'h0001 at col 32 -> probe_hit=1. Probe 16'h0001 at col 31, row 22 over an empty cell -> 0. Lock a cell there, then the same probe -> 1.
- Lock a shape with a cell in row 0 and no clears -> game_over=1 after FINISH, and lock_ready stays 0 through 10 cycles of lock_valid.
- Assert Reset during SHIFT -> grid all zero, state IDLE, lock_ready=1, lines_cleared=0, all immediately.
